// File: rtl/fc_dense_layer.sv
`default_nettype none
// ============================================================================
// Module   : fc_dense_layer
// Purpose  : Fully-connected (dense) layer. It multiplies a latched input
//            vector by an on-chip OUT_LEN x IN_LEN signed weight matrix.
//            The datapath is a single multiply-accumulate that runs once per
//            clock, so a full pass takes OUT_LEN*IN_LEN cycles.
// Ports    :
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   start      begin a pass (accepted in IDLE or DONE, ignored while busy)
//   in_vec     IN_LEN signed DATA_W-bit input elements
//   w_wr_en    weight write strobe (ignored while busy)
//   w_wr_addr  weight address = row*IN_LEN + column
//   w_wr_data  signed weight value
//   out_vec    OUT_LEN signed ACC_W-bit dot products (registered)
//   busy       high while the MAC sequence is running (registered)
//   done       level; results valid until the next accepted start or reset
// Revision : 1.0 - initial release
// ============================================================================
module fc_dense_layer #(
   parameter int IN_LEN  = 24,
   parameter int OUT_LEN = 8,
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = $clog2(IN_LEN*OUT_LEN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] in_vec [IN_LEN],
   input  logic                     w_wr_en,
   input  logic        [ADDR_W-1:0] w_wr_addr,
   input  logic signed [DATA_W-1:0] w_wr_data,
   output logic signed [ACC_W-1:0]  out_vec [OUT_LEN],
   output logic                     busy,
   output logic                     done
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int N_W = IN_LEN * OUT_LEN;
   localparam int K_W = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
   localparam int R_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam int P_W = 2 * DATA_W;

   localparam logic [K_W-1:0] K_LAST = K_W'(IN_LEN - 1);
   localparam logic [R_W-1:0] R_LAST = R_W'(OUT_LEN - 1);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   r_state;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic signed [DATA_W-1:0] r_weights [N_W];
   logic signed [DATA_W-1:0] r_x       [IN_LEN];
   logic signed [ACC_W-1:0]  r_out     [OUT_LEN];
   logic signed [ACC_W-1:0]  r_acc;
   logic        [K_W-1:0]    r_k;
   logic        [R_W-1:0]    r_r;
   // Linear weight index. It tracks r*IN_LEN + k incrementally, so the
   // weight fetch needs no multiplier.
   logic        [ADDR_W-1:0] r_widx;
   logic                     r_busy;
   logic                     r_done;

   // ------------------------------------------------------------------------
   // Datapath wires
   // ------------------------------------------------------------------------
   logic                     w_wr_ok;
   logic signed [DATA_W-1:0] w_w_cur;
   logic signed [DATA_W-1:0] w_x_cur;
   logic signed [P_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_acc_next;

   // A write is accepted only outside a pass and only to an in-range address.
   // A write on the same edge as an accepted start still lands, because the
   // state is not yet MAC at that edge.
   assign w_wr_ok = w_wr_en && (r_state != S_MAC) && (32'(w_wr_addr) < N_W);

   assign w_w_cur = r_weights[r_widx];
   assign w_x_cur = r_x[r_k];

   // Full-precision signed product. The size casts sign-extend the operands,
   // so the low P_W bits of the product are exact.
   assign w_prod = P_W'(w_w_cur) * P_W'(w_x_cur);

   generate
      if (ACC_W > P_W) begin : g_sext
         assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};
      end else begin : g_trunc
         // With ACC_W == P_W this is the product unchanged. A narrower
         // accumulator keeps the low bits, which is consistent with
         // modulo-2^ACC_W wrapping.
         assign w_prod_ext = w_prod[ACC_W-1:0];
      end
   endgenerate

   // Two's-complement add. It wraps modulo 2^ACC_W and does not saturate.
   assign w_acc_next = r_acc + w_prod_ext;

   // ------------------------------------------------------------------------
   // Weight store
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_W; i++) begin
            r_weights[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_W; i++) begin
            if (w_wr_ok && (w_wr_addr == ADDR_W'(i))) begin
               r_weights[i] <= w_wr_data;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM and accumulator, with registered busy and done
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_k     <= '0;
         r_r     <= '0;
         r_widx  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < OUT_LEN; i++) begin
            r_out[i] <= '0;
         end
         for (int i = 0; i < IN_LEN; i++) begin
            r_x[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // Snapshot the input so that later changes on in_vec cannot
                  // disturb the pass in progress.
                  for (int i = 0; i < IN_LEN; i++) begin
                     r_x[i] <= in_vec[i];
                  end
                  for (int i = 0; i < OUT_LEN; i++) begin
                     r_out[i] <= '0;
                  end
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_r     <= '0;
                  r_widx  <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_state <= S_MAC;
               end
            end

            S_MAC: begin
               // start is not examined here, so a restart during a pass is
               // ignored.
               r_widx <= r_widx + 1'b1;
               if (r_k != K_LAST) begin
                  r_acc <= w_acc_next;
                  r_k   <= r_k + 1'b1;
               end else begin
                  // Last column of the row: commit the finished dot product
                  // and begin the next row from zero.
                  r_out[r_r] <= w_acc_next;
                  r_acc      <= '0;
                  r_k        <= '0;
                  if (r_r != R_LAST) begin
                     r_r <= r_r + 1'b1;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (driven directly from registers)
   // ------------------------------------------------------------------------
   assign busy    = r_busy;
   assign done    = r_done;
   assign out_vec = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fc_dense_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_dense_layer
// Purpose  : Scoreboard bench for fc_dense_layer. Stimulus pushes the
//            expected row results and start edges into queues. A monitor
//            pops and compares them when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_dense_layer;

   localparam int IN_LEN  = 24;
   localparam int OUT_LEN = 8;
   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int ADDR_W  = 8;
   localparam int N_W     = IN_LEN * OUT_LEN;
   localparam int LAT     = 192;

   logic                     clk       = 1'b0;
   logic                     reset     = 1'b1;
   logic                     start     = 1'b0;
   logic                     w_wr_en   = 1'b0;
   logic        [ADDR_W-1:0] w_wr_addr = '0;
   logic signed [DATA_W-1:0] w_wr_data = '0;
   logic signed [DATA_W-1:0] in_vec  [IN_LEN];
   logic signed [ACC_W-1:0]  out_vec [OUT_LEN];
   logic                     busy;
   logic                     done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int st_edge = 0;
   logic prev_done = 1'b0;

   logic signed [ACC_W-1:0] exp_q[$];
   int                      start_q[$];

   fc_dense_layer #(
      .IN_LEN  (IN_LEN),
      .OUT_LEN (OUT_LEN),
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_vec    (in_vec),
      .w_wr_en   (w_wr_en),
      .w_wr_addr (w_wr_addr),
      .w_wr_data (w_wr_data),
      .out_vec   (out_vec),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: on each rising edge of done, check latency, exclusivity and rows.
   always @(negedge clk) begin
      if (done && !prev_done) begin
         check("pending_pass", start_q.size() > 0, 1);
         if (start_q.size() > 0) check("done_latency", cyc - start_q.pop_front(), LAT);
         check("busy_with_done", busy, 0);
         check("exp_available", exp_q.size() >= OUT_LEN, 1);
         if (exp_q.size() >= OUT_LEN) begin
            for (int r = 0; r < OUT_LEN; r++)
               check($sformatf("out_vec[%0d]", r), out_vec[r], exp_q.pop_front());
         end
      end
      prev_done = done;
   end

   task automatic load_const(input int v);
      for (int a = 0; a < N_W; a++) begin
         @(negedge clk);
         w_wr_en = 1'b1; w_wr_addr = ADDR_W'(a); w_wr_data = DATA_W'(v);
      end
      @(negedge clk);
      w_wr_en = 1'b0;
   endtask

   task automatic load_diag();
      for (int a = 0; a < N_W; a++) begin
         @(negedge clk);
         w_wr_en   = 1'b1;
         w_wr_addr = ADDR_W'(a);
         w_wr_data = ((a / IN_LEN) == (a % IN_LEN)) ? 16'sd1 : 16'sd0;
      end
      @(negedge clk);
      w_wr_en = 1'b0;
   endtask

   task automatic set_in_ramp();
      for (int k = 0; k < IN_LEN; k++) in_vec[k] = DATA_W'(k + 1);
   endtask

   task automatic set_in_const(input int v);
      for (int k = 0; k < IN_LEN; k++) in_vec[k] = DATA_W'(v);
   endtask

   task automatic push_const(input int v);
      for (int r = 0; r < OUT_LEN; r++) exp_q.push_back(ACC_W'(v));
   endtask

   task automatic pulse_start(input bit track);
      @(negedge clk);
      start   = 1'b1;
      st_edge = cyc + 1;
      if (track) start_q.push_back(st_edge);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("done_after_start", done, 0);
      // Scramble the input: the latched copy must be the one that is used.
      for (int k = 0; k < IN_LEN; k++) in_vec[k] = DATA_W'(k * 777 + 3);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in_const(0);
      #2 reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      for (int r = 0; r < OUT_LEN; r++) check($sformatf("rst_out[%0d]", r), out_vec[r], 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // All weights 1, ramp input: every row sums 1..24 = 300.
      load_const(1); set_in_ramp(); push_const(300);
      pulse_start(1); wait_done();

      // Identity on the first OUT_LEN columns.
      load_diag();
      for (int k = 0; k < IN_LEN; k++) in_vec[k] = DATA_W'(100 * k - 1000);
      for (int r = 0; r < OUT_LEN; r++) exp_q.push_back(ACC_W'(100 * r - 1000));
      pulse_start(1); wait_done();

      // -1 * 32767 * 24 = -786408.
      load_const(-1); set_in_const(32767); push_const(-786408);
      pulse_start(1); wait_done();

      // 24 * 2^30 wraps to 0 modulo 2^32.
      load_const(-32768); set_in_const(-32768); push_const(0);
      pulse_start(1); wait_done();

      // A weight write and a restart while busy must both be ignored.
      load_const(1); set_in_ramp(); push_const(300);
      pulse_start(1);
      while (cyc < st_edge + 49) @(negedge clk);
      w_wr_en = 1'b1; w_wr_addr = '0; w_wr_data = 16'sd100; start = 1'b1;
      @(negedge clk);
      w_wr_en = 1'b0; start = 1'b0;
      wait_done();
      set_in_ramp(); push_const(300);
      pulse_start(1); wait_done();

      // Reset at cycle 100 of a pass aborts it immediately.
      set_in_ramp();
      pulse_start(0);
      while (cyc < st_edge + 99) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      for (int r = 0; r < OUT_LEN; r++) check($sformatf("abort_out[%0d]", r), out_vec[r], 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      // The weights were cleared by reset, so every row is 0.
      set_in_ramp(); push_const(0);
      pulse_start(1); wait_done();
      // After the weights are reloaded, every row is 2 * 300.
      load_const(2); set_in_ramp(); push_const(600);
      pulse_start(1); wait_done();

      repeat (2) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("start_q_drained", start_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fc_dense_layer.md
# fc_dense_layer

Fully-connected (dense) layer stage placed directly downstream of `cnn_3filters`. It consumes the flattened max-pool vector (`pool_result`, 24 signed 16-bit values for 6×6×6 input, 3×3×3 filters and 3 filters) and multiplies it by an on-chip OUT_LEN×IN_LEN signed weight matrix. It produces OUT_LEN signed 32-bit dot products. One multiply-accumulate runs per clock. It moves the matrix-vector product, today computed behaviourally in simulation, into synthesizable RTL.

## Interface
Parameters:
- IN_LEN, 24, length of the input vector (flattened pool_result)
- OUT_LEN, 8, number of output neurons (weight rows)
- DATA_W, 16, signed width of inputs and weights
- ACC_W, 32, signed accumulator / output width
- ADDR_W, $clog2(IN_LEN*OUT_LEN), weight write address width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous and active-low (0 = in reset)
- start  input  1  begin a pass; sampled on clk; typically driven by `cnn_3filters.done`
- in_vec  input  [DATA_W-1:0] signed × IN_LEN (unpacked)  input vector, element k = pool_result[k]
- w_wr_en  input  1  weight write strobe
- w_wr_addr  input  ADDR_W  weight address = r*IN_LEN + k
- w_wr_data  input  DATA_W signed  weight value
- out_vec  output  [ACC_W-1:0] signed × OUT_LEN (unpacked)  result, element r = Σk W[r][k]·in_vec[k]
- busy  output  1  high while computing
- done  output  1  level, high when results are valid; held until next accepted start or reset

## Operation
- Weight store: OUT_LEN*IN_LEN registers of DATA_W bits.
  - Written on a clk edge when w_wr_en=1 and the block is not busy.
  - Writes while busy are ignored. Addresses ≥ OUT_LEN*IN_LEN are ignored.
- FSM states: IDLE, MAC, DONE.
- IDLE, or DONE, with start=1:
  - latch in_vec into an internal copy
  - clear the accumulator and all out_vec entries
  - set row r=0, column k=0
  - go to MAC; done←0
- MAC, each cycle:
  - acc_next = acc + sext(W[r*IN_LEN+k] · x[k]). The product is a full 2·DATA_W signed value, sign-extended to ACC_W.
  - If k<IN_LEN-1: acc←acc_next, k←k+1.
  - If k=IN_LEN-1: out_vec[r]←acc_next, acc←0, k←0.
    - If r<OUT_LEN-1: r←r+1.
    - Else go to DONE.
- DONE: done=1 and out_vec is stable. start=1 restarts as from IDLE.
- Arithmetic: two's complement, wraps modulo 2^ACC_W, no saturation, no rounding.
- in_vec changes after the start edge have no effect on the current pass.
- start while in MAC is ignored.
- A weight write and start on the same edge: the write is applied and the pass begins. The first MAC uses the new weight only if it was written at least one edge earlier; same-edge writes are not required to be seen.

## Timing
- Reset (reset=0, asynchronous):
  - out_vec all 0, weights all 0, busy=0, done=0
  - state IDLE, acc=0, r=k=0
  - Release is synchronous to clk.
- busy=1 and done=0 in the cycle after the start edge (E0).
- out_vec[r] is written at edge E0 + (r+1)·IN_LEN.
- done rises and busy falls after edge E0 + OUT_LEN·IN_LEN (192 cycles at defaults).
- busy and done are never high together.
- Reset asserted mid-pass aborts immediately to the reset values. A pass after release requires weights to be reloaded.
- Back-to-back: start held high in DONE starts a new pass on the next edge, and done drops.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Load all weights = 1, in_vec[k] = k+1 (1..24), pulse start:
  - every out_vec[r] = 300
  - done rises exactly 192 cycles after the start edge
- Diagonal weights (W[r][r]=1, others 0), in_vec[k] = 100·k - 1000:
  - out_vec[r] = 100·r - 1000 (r = 0..7)
  - out_vec[0] = -1000, out_vec[7] = -300
- All weights = -1, all in_vec = 32767:
  - every out_vec[r] = -786408
- Wrap: all weights = -32768, all in_vec = -32768:
  - 24·2^30 mod 2^32 gives every out_vec[r] = 0 with no saturation flag
- Pass 1 running: write weight address 0 while busy, and pulse start at cycle 50:
  - both are ignored
  - results match the pre-loaded weights
  - done timing is unchanged (192 cycles)
- Assert reset=0 at cycle 100 of a pass:
  - busy=0, done=0, out_vec=0 immediately
  - after release, a new pass with reloaded weights gives the expected values
